// File: rtl/pdh_pkg.sv
// Shared types and constants for the pdh converter stream blocks.
package pdh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } dac_tx_state_t;

  localparam int                    LANE_WIDTH  = 16;
  localparam logic [LANE_WIDTH-1:0] MIDSCALE_OB = 16'h2000;
  localparam logic [LANE_WIDTH-1:0] MIDSCALE_TC = 16'h0000;

endpackage

// File: rtl/pdh_sync_fifo.sv
// Single-clock FIFO with synchronous clear; read data is the head entry (show-ahead).
module pdh_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dac_axis_tx.sv
// DAC sample pairs -> buffered AXI-Stream master; repeats the last word on starvation.
// Optional stat counters built when DAC_TX_STATS_EN is defined.
module dac_axis_tx
  import pdh_pkg::*;
#(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter bit OFFSET_BINARY    = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [DAC_DATA_WIDTH-1:0]   dac_1_data_i,
  input  logic [DAC_DATA_WIDTH-1:0]   dac_2_data_i,
  input  logic                        dac_valid_i,
  output logic                        dac_ready_o,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata_o,
  output logic                        M_AXIS_tvalid_o,
  input  logic                        M_AXIS_tready_i,
  output logic                        underrun_o,
  input  logic                        clr_stats_i,
  output logic [15:0]                 underrun_cnt_o,
  output logic [15:0]                 overflow_cnt_o
);
  localparam int NUM_LANES = 2;
  localparam int LW        = AXIS_TDATA_WIDTH / NUM_LANES;
  localparam logic [LW-1:0] MIDSCALE = OFFSET_BINARY ? LW'(MIDSCALE_OB) : LW'(MIDSCALE_TC);
  localparam logic [AXIS_TDATA_WIDTH-1:0] HOLD_WORD = {MIDSCALE, MIDSCALE};
  localparam logic [DAC_DATA_WIDTH-1:0]   MSB_MASK  = {1'b1, {(DAC_DATA_WIDTH-1){1'b0}}};

  dac_tx_state_t                          state;
  logic [NUM_LANES-1:0][DAC_DATA_WIDTH-1:0] samples;
  logic [NUM_LANES-1:0][LW-1:0]           lanes;
  logic [AXIS_TDATA_WIDTH-1:0]            fifo_dout, tdata_q;
  logic tvalid_q, underrun_q;
  logic full, empty, active, beat, push, pop, clear, ev_underrun, ev_overflow;

  assign samples = {dac_2_data_i, dac_1_data_i};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    if (OFFSET_BINARY) begin : g_ob
      assign lanes[i] = {{(LW-DAC_DATA_WIDTH){1'b0}}, samples[i] ^ MSB_MASK};
    end else begin : g_tc
      assign lanes[i] = {{(LW-DAC_DATA_WIDTH){samples[i][DAC_DATA_WIDTH-1]}}, samples[i]};
    end
  end

  assign active      = (state == ST_PRIME) || (state == ST_RUN);
  assign dac_ready_o = active && !full;
  assign beat        = tvalid_q && M_AXIS_tready_i;
  assign push        = dac_valid_i && dac_ready_o;
  assign pop         = (state == ST_PRIME && en_i && !empty) || (state == ST_RUN && beat && !empty);
  assign clear       = (state == ST_FLUSH) && (!tvalid_q || M_AXIS_tready_i);
  assign ev_underrun = (state == ST_RUN) && beat && empty;
  assign ev_overflow = active && dac_valid_i && !dac_ready_o;

  pdh_sync_fifo #(.WIDTH(AXIS_TDATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst_i), .clear(clear), .push(push), .pop(pop),
    .din(lanes), .dout(fifo_dout), .full(full), .empty(empty)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      tvalid_q   <= 1'b0;
      tdata_q    <= HOLD_WORD;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      case (state)
        ST_IDLE: if (en_i) state <= ST_PRIME;
        ST_PRIME: begin
          if (!en_i) state <= ST_FLUSH;
          else if (!empty) begin
            tdata_q  <= fifo_dout;
            tvalid_q <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (beat) begin
            if (!empty) tdata_q <= fifo_dout;
            else        underrun_q <= 1'b1;
          end
          if (!en_i) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Word in flight must complete its handshake before the stream is parked.
          if (!tvalid_q || M_AXIS_tready_i) begin
            tvalid_q <= 1'b0;
            tdata_q  <= HOLD_WORD;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign M_AXIS_tdata_o  = tdata_q;
  assign M_AXIS_tvalid_o = tvalid_q;
  assign underrun_o      = underrun_q;

`ifdef DAC_TX_STATS_EN
  logic [15:0] ucnt, ocnt;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ucnt <= '0;
      ocnt <= '0;
    end else if (clr_stats_i) begin
      ucnt <= '0;
      ocnt <= '0;
    end else begin
      if (ev_underrun && ucnt != 16'hFFFF) ucnt <= ucnt + 16'd1;
      if (ev_overflow && ocnt != 16'hFFFF) ocnt <= ocnt + 16'd1;
    end
  end
  assign underrun_cnt_o = ucnt;
  assign overflow_cnt_o = ocnt;
`else
  logic unused_stats;
  assign unused_stats   = clr_stats_i ^ ev_underrun ^ ev_overflow;
  assign underrun_cnt_o = '0;
  assign overflow_cnt_o = '0;
`endif

endmodule
